gcd_cu: RTL and testbench

Control unit for the subtraction-based GCD datapath (`dp`). It accepts an operand pair with a start pulse and serialises both operands onto the datapath's shared `din` bus. It then steps the datapath's x/y registers through repeated subtraction until the equal flag is seen, latches the result, and reports completion with a one-cycle `done` pulse. It also short-circuits zero operands, which would never converge in the datapath, and bounds run time with an iteration watchdog.

---
 rtl/gcd_cu.sv | 131 +++++++++++++
 tb/tb_gcd_cu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_cu.sv
// Control unit for the subtraction-based GCD datapath: serialises operands onto din,
// steers x/y subtraction until equality, and bounds run time with an iteration watchdog.
module gcd_cu #(
   parameter int WIDTH    = 8,
   parameter int MAX_ITER = 255,
   localparam int CW      = $clog2(MAX_ITER + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             x_eq_y,
   input  logic             x_gt_y,
   input  logic [WIDTH-1:0] gcd_rslt,
   output logic [WIDTH-1:0] din,
   output logic             xhold,
   output logic             xload,
   output logic             yhold,
   output logic             yload,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [CW-1:0]    iter_count,
   output logic             error
);

   // state    | meaning
   // S_IDLE   | waiting for start; zero operands finish without touching the datapath
   // S_LOAD_X | drive a_q onto din, write x
   // S_LOAD_Y | drive b_q onto din, write y
   // S_RUN    | one subtraction per cycle until x==y or the watchdog trips
   // S_FINISH | one-cycle done pulse
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_X,
      S_LOAD_Y,
      S_RUN,
      S_FINISH
   } state_t;

   localparam logic [CW-1:0] MAX_C = CW'(MAX_ITER);

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic [CW-1:0]    iter_q;
   logic             error_q;
   logic             wd_hit;

   assign wd_hit     = (iter_q == MAX_C);
   assign result     = result_q;
   assign iter_count = iter_q;
   assign error      = error_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         iter_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  iter_q   <= '0;
                  error_q  <= 1'b0;
                  result_q <= '0;
                  // a zero operand never converges by subtraction; gcd(0,v)=v
                  if ((a == '0) || (b == '0)) begin
                     result_q <= a | b;
                     state_q  <= S_FINISH;
                  end else begin
                     state_q  <= S_LOAD_X;
                  end
               end
            end
            S_LOAD_X: state_q <= S_LOAD_Y;
            S_LOAD_Y: state_q <= S_RUN;
            S_RUN: begin
               if (x_eq_y) begin
                  result_q <= gcd_rslt;
                  state_q  <= S_FINISH;
               end else if (wd_hit) begin
                  error_q  <= 1'b1;
                  result_q <= '0;
                  state_q  <= S_FINISH;
               end else begin
                  iter_q   <= iter_q + CW'(1);
               end
            end
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   // Loads in RUN follow the live comparator flags so each edge performs one subtraction.
   always_comb begin
      din   = '0;
      xhold = 1'b1;
      yhold = 1'b1;
      xload = 1'b0;
      yload = 1'b0;
      busy  = (state_q != S_IDLE);
      done  = (state_q == S_FINISH);
      case (state_q)
         S_LOAD_X: begin
            din   = a_q;
            xhold = 1'b0;
         end
         S_LOAD_Y: begin
            din   = b_q;
            yhold = 1'b0;
         end
         S_RUN: begin
            if (!x_eq_y && !wd_hit) begin
               xload = x_gt_y;
               yload = !x_gt_y;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gcd_cu.sv
// Bench for gcd_cu: two instances (default watchdog and MAX_ITER=10), each driving a
// behavioural subtraction datapath; expected results are queued at launch and popped at done.
module tb_gcd_cu;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic sel = 1'b0;

   always #5 clk = ~clk;

   // instance 0: default MAX_ITER
   logic       eq0, gt0, xh0, xl0, yh0, yl0, busy0, done0, err0;
   logic [7:0] x0 = '0, y0 = '0, din0, res0, it0;
   // instance 1: MAX_ITER = 10
   logic       eq1, gt1, xh1, xl1, yh1, yl1, busy1, done1, err1;
   logic [7:0] x1 = '0, y1 = '0, din1, res1;
   logic [3:0] it1;

   gcd_cu u0 (
      .clk(clk), .rst_n(rst_n), .start(start & !sel), .a(a), .b(b),
      .x_eq_y(eq0), .x_gt_y(gt0), .gcd_rslt(x0), .din(din0),
      .xhold(xh0), .xload(xl0), .yhold(yh0), .yload(yl0),
      .busy(busy0), .done(done0), .result(res0), .iter_count(it0), .error(err0)
   );

   gcd_cu #(.WIDTH(8), .MAX_ITER(10)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .a(a), .b(b),
      .x_eq_y(eq1), .x_gt_y(gt1), .gcd_rslt(x1), .din(din1),
      .xhold(xh1), .xload(xl1), .yhold(yh1), .yload(yl1),
      .busy(busy1), .done(done1), .result(res1), .iter_count(it1), .error(err1)
   );

   // datapath models: load (difference) has priority over hold-release (din)
   assign eq0 = (x0 == y0);
   assign gt0 = (x0 > y0);
   assign eq1 = (x1 == y1);
   assign gt1 = (x1 > y1);

   always @(posedge clk) begin
      if (xl0)       x0 <= gt0 ? x0 - y0 : 8'd0;
      else if (!xh0) x0 <= din0;
      if (yl0)       y0 <= gt0 ? 8'd0 : y0 - x0;
      else if (!yh0) y0 <= din0;
      if (xl1)       x1 <= gt1 ? x1 - y1 : 8'd0;
      else if (!xh1) x1 <= din1;
      if (yl1)       y1 <= gt1 ? 8'd0 : y1 - x1;
      else if (!yh1) y1 <= din1;
   end

   logic       done_s, busy_s, err_s, xl_s, yl_s, xh_s, yh_s;
   logic [7:0] res_s, it_s;
   assign done_s = sel ? done1 : done0;
   assign busy_s = sel ? busy1 : busy0;
   assign err_s  = sel ? err1  : err0;
   assign res_s  = sel ? res1  : res0;
   assign it_s   = sel ? {4'd0, it1} : it0;
   assign xl_s   = sel ? xl1 : xl0;
   assign yl_s   = sel ? yl1 : yl0;
   assign xh_s   = sel ? xh1 : xh0;
   assign yh_s   = sel ? yh1 : yh0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   logic saw_load = 1'b0;
   logic saw_hold_drop = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("load_exclusive_u0", {31'd0, xl0 & yl0}, 32'd0);
         chk("load_exclusive_u1", {31'd0, xl1 & yl1}, 32'd0);
         if (xl_s || yl_s) saw_load = 1'b1;
         if (!xh_s || !yh_s) saw_hold_drop = 1'b1;
      end
   end

   typedef struct {
      logic [7:0] res;
      logic [7:0] it;
      logic       err;
      int         lat;
   } exp_t;
   exp_t sb[$];

   // Reference: plain subtraction GCD with watchdog; lat = index k of the edge E_k
   // after which done is high (zero operands finish on the accepting edge E0).
   function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input int max_it);
      exp_t e;
      int x = av;
      int y = bv;
      int n = 0;
      e.err = 1'b0;
      if (av == 0 || bv == 0) begin
         e.res = av | bv; e.it = 8'd0; e.lat = 0;
         return e;
      end
      while (x != y) begin
         if (n == max_it) begin
            e.err = 1'b1; e.res = 8'd0; e.it = 8'(max_it); e.lat = max_it + 3;
            return e;
         end
         if (x > y) x -= y; else y -= x;
         n++;
      end
      e.res = 8'(x); e.it = 8'(n); e.lat = n + 3;
      return e;
   endfunction

   task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input bit inj, input string tag);
      exp_t e;
      int k;
      @(negedge clk);
      sel = s; a = av; b = bv; start = 1'b1;
      sb.push_back(model(av, bv, s ? 10 : 255));
      @(posedge clk);
      #1 start = 1'b0;
      saw_load = 1'b0;
      saw_hold_drop = 1'b0;
      chk({tag, "_busy_rise"}, {31'd0, busy_s}, 32'd1);
      k = 0;
      while (!done_s && k < 400) begin
         if (inj && k == 3) begin start = 1'b1; a = 8'd9; b = 8'd6; end
         if (inj && k == 4) start = 1'b0;
         @(posedge clk);
         #1 k++;
      end
      start = 1'b0;
      e = sb.pop_front();
      chk({tag, "_done_seen"}, {31'd0, done_s}, 32'd1);
      chk({tag, "_latency"}, k, e.lat);
      chk({tag, "_result"}, {24'd0, res_s}, {24'd0, e.res});
      chk({tag, "_iter"}, {24'd0, it_s}, {24'd0, e.it});
      chk({tag, "_error"}, {31'd0, err_s}, {31'd0, e.err});
      chk({tag, "_busy_at_done"}, {31'd0, busy_s}, 32'd1);
      @(posedge clk);
      #1;
      chk({tag, "_done_fall"}, {31'd0, done_s}, 32'd0);
      chk({tag, "_busy_fall"}, {31'd0, busy_s}, 32'd0);
      chk({tag, "_result_hold"}, {24'd0, res_s}, {24'd0, e.res});
   endtask

   task automatic chk_reset_u0(input string tag);
      chk({tag, "_busy"}, {31'd0, busy0}, 32'd0);
      chk({tag, "_done"}, {31'd0, done0}, 32'd0);
      chk({tag, "_result"}, {24'd0, res0}, 32'd0);
      chk({tag, "_iter"}, {24'd0, it0}, 32'd0);
      chk({tag, "_error"}, {31'd0, err0}, 32'd0);
      chk({tag, "_din"}, {24'd0, din0}, 32'd0);
      chk({tag, "_ctl"}, {28'd0, xh0, yh0, xl0, yl0}, 32'b1100);
   endtask

   initial begin
      #1;
      chk_reset_u0("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      run_op(1'b0, 8'd48, 8'd18, 1'b0, "g48_18");

      run_op(1'b0, 8'd7, 8'd7, 1'b0, "g7_7");
      chk("g7_7_no_loads", {31'd0, saw_load}, 32'd0);

      run_op(1'b0, 8'd0, 8'd9, 1'b0, "g0_9");
      chk("g0_9_no_loads", {31'd0, saw_load}, 32'd0);
      chk("g0_9_holds", {31'd0, saw_hold_drop}, 32'd0);
      run_op(1'b0, 8'd0, 8'd0, 1'b0, "g0_0");

      run_op(1'b0, 8'd255, 8'd1, 1'b0, "g255_1");
      run_op(1'b1, 8'd255, 8'd1, 1'b0, "wd255_1");
      run_op(1'b1, 8'd7, 8'd7, 1'b0, "wd_clear");

      run_op(1'b0, 8'd48, 8'd18, 1'b1, "ignore_start");
      run_op(1'b0, 8'd9, 8'd6, 1'b0, "g9_6");

      // asynchronous reset mid-run: 255/1 has done three subtractions by E5
      @(negedge clk);
      sel = 1'b0; a = 8'd255; b = 8'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrun_iter", {24'd0, it0}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk_reset_u0("async_reset");
      @(negedge clk) rst_n = 1'b1;

      run_op(1'b0, 8'd48, 8'd18, 1'b0, "after_reset");

      if (sb.size() != 0) chk("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
